mcu_ahb_cmd_master: RTL

Single-outstanding AHB-Lite initiator. It turns a valid/ready command interface into one AHB-Lite SINGLE transfer per command. Used by debug/boot-loader bridges to reach system-controller and peripheral registers on the MCU AHB fabric. It handles lane replication and extraction, wait states, the two-cycle ERROR response, and alignment checking. It returns each result on a valid/ready response channel.

---
 rtl/mcu_ahb_const_pkg.sv | 19 +
 rtl/mcu_ahb_lane.sv | 27 ++
 rtl/mcu_ahb_cmd_master.sv | 118 +++++++++++
 3 files changed

// File: rtl/mcu_ahb_const_pkg.sv
// mcu_ahb_const_pkg: shared AHB-Lite codes, response status codes and initiator FSM states.
//   HTRANS_* : transfer type codes (only IDLE and NONSEQ are issued)
//   HSIZE_*  : transfer size codes
//   HBURST_SINGLE / HPROT_DEFAULT : constant burst type and protection
//   RSP_*    : response status codes
//   state_t  : command-master FSM states
package mcu_ahb_const_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
  localparam logic [1:0] RSP_OKAY      = 2'b00;
  localparam logic [1:0] RSP_ERROR     = 2'b01;
  localparam logic [1:0] RSP_UNALIGNED = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;
endpackage

// File: rtl/mcu_ahb_lane.sv
// mcu_ahb_lane: combinational AHB byte-lane helper shared by initiators.
//   i_size/i_addr : transfer size and low address bits
//   i_wdata       : right-justified write data  -> o_wdata lane-replicated
//   i_rdata       : raw HRDATA                  -> o_rdata selected lane, zero-extended
//   o_fault       : size/address misaligned or size wider than a word
module mcu_ahb_lane
  import mcu_ahb_const_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_fault
);
  logic [31:0] w_shift;
  always_comb begin
    w_shift = i_rdata >> {i_addr, 3'b000};
    o_fault = (i_size == HSIZE_HALF && i_addr[0]) || (i_size == HSIZE_WORD && i_addr != 2'b00) ||
              (i_size > HSIZE_WORD);
    o_wdata = (i_size == HSIZE_BYTE) ? {4{i_wdata[7:0]}} :
              (i_size == HSIZE_HALF) ? {2{i_wdata[15:0]}} : i_wdata;
    o_rdata = (i_size == HSIZE_BYTE) ? {24'b0, w_shift[7:0]} :
              (i_size == HSIZE_HALF) ? {16'b0, w_shift[15:0]} : i_rdata;
  end
endmodule

// File: rtl/mcu_ahb_cmd_master.sv
// mcu_ahb_cmd_master: single-outstanding AHB-Lite initiator, one SINGLE transfer per command.
//   HCLK/PORESETn           : clock, asynchronous active-low reset
//   cmd_*                   : valid/ready command channel (write, addr, size, right-justified wdata)
//   rsp_*                   : valid/ready response channel (rdata, status, saturating wait count)
//   busy                    : high whenever a command is in flight
//   HTRANS..HWDATA          : AHB-Lite master outputs; HREADY/HRESP/HRDATA : fabric inputs
module mcu_ahb_cmd_master
  import mcu_ahb_const_pkg::*;
#(
  parameter int WAIT_W = 8
) (
  input  logic              HCLK,
  input  logic              PORESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [31:0]       cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic [WAIT_W-1:0] rsp_wait,
  output logic              busy,
  output logic [1:0]        HTRANS,
  output logic [31:0]       HADDR,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [31:0]       HRDATA
);
  state_t      r_state, w_state_nxt;
  logic [31:0] r_wdata;
  logic [31:0] w_wrep, w_rext;
  logic        w_fault;
  // In IDLE the lane helper looks at the incoming command (fault check and
  // replication); afterwards it looks at the latched transfer for read extraction.
  mcu_ahb_lane u_lane (
    .i_size  (r_state == ST_IDLE ? cmd_size : HSIZE),
    .i_addr  (r_state == ST_IDLE ? cmd_addr[1:0] : HADDR[1:0]),
    .i_wdata (cmd_wdata),
    .i_rdata (HRDATA),
    .o_wdata (w_wrep),
    .o_rdata (w_rext),
    .o_fault (w_fault)
  );
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DEFAULT;
  always_ff @(posedge HCLK or negedge PORESETn)
    if (!PORESETn) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = cmd_valid ? (w_fault ? ST_RESP : ST_ADDR) : ST_IDLE;
      ST_ADDR: w_state_nxt = HREADY ? ST_DATA : ST_ADDR;
      ST_DATA: w_state_nxt = HREADY ? ST_RESP : ST_DATA;
      ST_RESP: w_state_nxt = rsp_ready ? ST_IDLE : ST_RESP;
      default: w_state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge HCLK or negedge PORESETn) begin
    if (!PORESETn) begin
      HTRANS     <= HTRANS_IDLE;
      HADDR      <= '0;
      HSIZE      <= '0;
      HWRITE     <= 1'b0;
      HWDATA     <= '0;
      r_wdata    <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= RSP_OKAY;
      rsp_wait   <= '0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (cmd_valid) begin
            r_wdata <= w_wrep;
            if (w_fault) begin
              rsp_valid  <= 1'b1;
              rsp_status <= RSP_UNALIGNED;
              rsp_rdata  <= '0;
            end else begin
              HTRANS <= HTRANS_NONSEQ;
              HADDR  <= cmd_addr;
              HSIZE  <= cmd_size;
              HWRITE <= cmd_write;
            end
          end
        ST_ADDR:
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            HWDATA <= r_wdata;
          end
        ST_DATA:
          if (!HREADY) rsp_wait <= (&rsp_wait) ? rsp_wait : rsp_wait + 1'b1;
          else begin
            rsp_valid  <= 1'b1;
            rsp_status <= HRESP ? RSP_ERROR : RSP_OKAY;
            rsp_rdata  <= (HRESP || HWRITE) ? 32'b0 : w_rext;
          end
        ST_RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_wait  <= '0;
          end
        default: ;
      endcase
    end
  end
endmodule
